// File: rtl/vscan_pkg.sv
// Shared types and constants for the vector scan controller and its 32-bit detector.
package vscan_pkg;

  localparam int WORD_W    = 32;
  localparam int DET_POS_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/vscan_lsb_detect.sv
// Combinational lowest-set-bit encoder for one 32-bit word; pos_o is 0 when no bit is set.
module vscan_lsb_detect
  import vscan_pkg::*;
(
  input  logic [WORD_W-1:0]    word_i,
  output logic                 found_o,
  output logic [DET_POS_W-1:0] pos_o
);

  always_comb begin
    found_o = |word_i;
    pos_o   = '0;
    // Scan downward so the last assignment is the lowest set bit.
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (word_i[i]) begin
        pos_o = DET_POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/vector_scan_ctrl.sv
// Finds the lowest set bit of a NUM_WORDS x 32-bit vector by streaming words through one detector.
// Optional VSCAN_EARLY_EXIT_EN: finish as soon as a registered detector hit is seen.
module vector_scan_ctrl
  import vscan_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int POS_W     = $clog2(NUM_WORDS * WORD_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_found,
  output logic [POS_W-1:0]            out_pos,
  output logic                        busy
);

  localparam int             IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_WORDS*WORD_W-1:0] vec_q;
  logic                        found_q, found_d;
  logic [POS_W-1:0]            pos_q, pos_d;

  logic                        res_vld_q;
  logic                        res_found_q;
  logic [DET_POS_W-1:0]        res_pos_q;
  logic [IDX_W-1:0]            res_tag_q;

  logic [WORD_W-1:0]           det_word;
  logic                        det_found;
  logic [DET_POS_W-1:0]        det_pos;
  logic                        accept;
  logic                        hit;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign hit       = res_vld_q && res_found_q;
  assign out_valid = (state_q == DONE);
  assign out_found = found_q;
  assign out_pos   = pos_q;
  assign busy      = (state_q != IDLE);

  // Detector input is forced to zero outside SCAN so it does not toggle needlessly.
  always_comb begin
    det_word = '0;
    if (state_q == SCAN) begin
      det_word = vec_q[WORD_W*int'(idx_q) +: WORD_W];
    end
  end

  vscan_lsb_detect u_det (
    .word_i  (det_word),
    .found_o (det_found),
    .pos_o   (det_pos)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    found_d = found_q;
    pos_d   = pos_q;

    // First registered hit wins; words arrive in ascending order so it is the lowest.
    if (hit && !found_q && (state_q == SCAN || state_q == WAIT)) begin
      found_d = 1'b1;
      pos_d   = (POS_W'(res_tag_q) << DET_POS_W) | POS_W'(res_pos_q);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          idx_d   = '0;
          found_d = 1'b0;
          pos_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = WAIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
`ifdef VSCAN_EARLY_EXIT_EN
        if (hit) begin
          state_d = DONE;
          idx_d   = '0;
        end
`endif
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      found_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      pos_q   <= pos_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
    end else if (accept) begin
      vec_q <= in_data;
    end
  end

  // Detector pipeline stage: result is tagged with the word index that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_q   <= 1'b0;
      res_found_q <= 1'b0;
      res_pos_q   <= '0;
      res_tag_q   <= '0;
    end else begin
      res_vld_q   <= (state_q == SCAN);
      res_found_q <= det_found;
      res_pos_q   <= det_pos;
      res_tag_q   <= idx_q;
    end
  end

endmodule
